// File: rtl/rv32i_pkg.sv
// Shared rv32i types and constants.
// Latency: none (declarations only).
// Backpressure: n/a.
// Contents: REG_ADDR_W, XLEN, reg_addr_t, word_t, REG_ZERO.
package rv32i_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       word_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/rv32i_fwd_mux.sv
// Per-read-port forwarding select and hazard detection.
// Latency: purely combinational.
// Backpressure: raises hazard when the operand cannot be supplied this cycle.
// Ports: rs_reg/rs_used/rf_data (port request), fwd_* (forwarding sources,
//        index 0 youngest), busy (scoreboard), operand/hazard (results).
module rv32i_fwd_mux
    import rv32i_pkg::reg_addr_t;
    import rv32i_pkg::REG_ZERO;
#(
    parameter int NUM_FWD = 3,
    parameter int XLEN    = 32
) (
    input  logic [4:0]                    rs_reg,
    input  logic                          rs_used,
    input  logic [XLEN-1:0]               rf_data,
    input  logic [NUM_FWD-1:0]            fwd_en,
    input  logic [NUM_FWD-1:0][4:0]       fwd_reg,
    input  logic [NUM_FWD-1:0][XLEN-1:0]  fwd_data,
    input  logic [NUM_FWD-1:0]            fwd_ready,
    input  logic [31:0]                   busy,
    output logic [XLEN-1:0]               operand,
    output logic                          hazard
);

    logic hit;
    logic sel_ready;

    always_comb begin
        hit       = 1'b0;
        sel_ready = 1'b1;
        operand   = rf_data;
        // Walk oldest to youngest so the youngest matching source wins.
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_en[i] && (reg_addr_t'(fwd_reg[i]) == reg_addr_t'(rs_reg)) &&
                (reg_addr_t'(rs_reg) != REG_ZERO)) begin
                hit       = 1'b1;
                operand   = fwd_data[i];
                sel_ready = fwd_ready[i];
            end
        end
        if (reg_addr_t'(rs_reg) == REG_ZERO) begin
            operand = '0;
        end
        hazard = rs_used && ((hit && !sel_ready) || busy[rs_reg]);
    end

endmodule

// File: rtl/rv32i_hazardunit.sv
// Operand forwarding, load-use/long-op hazard detection and ID/EX staging.
// Latency: stall combinational; decode to EX outputs 1 cycle.
// Backpressure: stall holds IF/ID; a bubble enters EX on stall, flush or idle.
// Ports: clk/reset, id_* (decode request), fwd_* (forwarding sources),
//        long_done* (long-op completion), flush, stall, ex_* (ID/EX), stall_count.
module rv32i_hazardunit
    import rv32i_pkg::reg_addr_t;
    import rv32i_pkg::REG_ZERO;
#(
    parameter int NUM_RD  = 2,
    parameter int NUM_FWD = 3,
    parameter int XLEN    = rv32i_pkg::XLEN
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          id_valid,
    input  logic [NUM_RD-1:0][4:0]        id_rs_reg,
    input  logic [NUM_RD-1:0]             id_rs_used,
    input  logic [NUM_RD-1:0][XLEN-1:0]   id_rf_data,
    input  logic                          id_wb_en,
    input  logic [4:0]                    id_wb_reg,
    input  logic                          id_long,
    input  logic [NUM_FWD-1:0]            fwd_en,
    input  logic [NUM_FWD-1:0][4:0]       fwd_reg,
    input  logic [NUM_FWD-1:0][XLEN-1:0]  fwd_data,
    input  logic [NUM_FWD-1:0]            fwd_ready,
    input  logic                          long_done,
    input  logic [4:0]                    long_done_reg,
    input  logic                          flush,
    output logic                          stall,
    output logic                          ex_valid,
    output logic [NUM_RD-1:0][XLEN-1:0]   ex_rs_data,
    output logic                          ex_wb_en,
    output logic [4:0]                    ex_wb_reg,
    output logic [31:0]                   stall_count
);

    logic [31:1]                  busy_q;
    logic [31:1]                  busy_nxt;
    logic [31:0]                  busy_vec;
    logic [NUM_RD-1:0]            port_hazard;
    logic [NUM_RD-1:0][XLEN-1:0]  operand;
    logic                         waw;
    logic                         issue;
    logic                         busy_set;

    // x0 can never be busy.
    assign busy_vec = {busy_q, 1'b0};

    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        rv32i_fwd_mux #(
            .NUM_FWD (NUM_FWD),
            .XLEN    (XLEN)
        ) u_fwd_mux (
            .rs_reg    (id_rs_reg[p]),
            .rs_used   (id_rs_used[p]),
            .rf_data   (id_rf_data[p]),
            .fwd_en    (fwd_en),
            .fwd_reg   (fwd_reg),
            .fwd_data  (fwd_data),
            .fwd_ready (fwd_ready),
            .busy      (busy_vec),
            .operand   (operand[p]),
            .hazard    (port_hazard[p])
        );
    end

    assign waw      = id_wb_en && busy_vec[id_wb_reg] && (reg_addr_t'(id_wb_reg) != REG_ZERO);
    assign stall    = id_valid && !flush && ((|port_hazard) || waw);
    assign issue    = id_valid && !stall && !flush;
    assign busy_set = issue && id_long && id_wb_en && (reg_addr_t'(id_wb_reg) != REG_ZERO);

    // Set beats clear when a new long op re-targets the register just completed.
    always_comb begin
        busy_nxt = '0;
        for (int r = 1; r < 32; r++) begin
            busy_nxt[r] = (busy_set && (id_wb_reg == 5'(r))) ||
                          (busy_q[r] && !(long_done && (long_done_reg == 5'(r))));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q      <= '0;
            ex_valid    <= 1'b0;
            ex_wb_en    <= 1'b0;
            ex_wb_reg   <= '0;
            ex_rs_data  <= '0;
            stall_count <= '0;
        end else begin
            busy_q <= busy_nxt;
            if (issue) begin
                ex_valid   <= 1'b1;
                ex_rs_data <= operand;
                // Long ops retire through long_done, never through EX.
                ex_wb_en   <= id_wb_en && !id_long;
                ex_wb_reg  <= id_wb_reg;
            end else begin
                ex_valid <= 1'b0;
                ex_wb_en <= 1'b0;
            end
            if (stall && (stall_count != 32'hFFFF_FFFF)) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_hazardunit.sv
module tb_rv32i_hazardunit;

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid;
    logic [1:0][4:0]   id_rs_reg;
    logic [1:0]        id_rs_used;
    logic [1:0][31:0]  id_rf_data;
    logic              id_wb_en;
    logic [4:0]        id_wb_reg;
    logic              id_long;
    logic [2:0]        fwd_en;
    logic [2:0][4:0]   fwd_reg;
    logic [2:0][31:0]  fwd_data;
    logic [2:0]        fwd_ready;
    logic              long_done;
    logic [4:0]        long_done_reg;
    logic              flush;
    logic              stall;
    logic              ex_valid;
    logic [1:0][31:0]  ex_rs_data;
    logic              ex_wb_en;
    logic [4:0]        ex_wb_reg;
    logic [31:0]       stall_count;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    rv32i_hazardunit #(.NUM_RD(2), .NUM_FWD(3), .XLEN(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (id_valid),
        .id_rs_reg     (id_rs_reg),
        .id_rs_used    (id_rs_used),
        .id_rf_data    (id_rf_data),
        .id_wb_en      (id_wb_en),
        .id_wb_reg     (id_wb_reg),
        .id_long       (id_long),
        .fwd_en        (fwd_en),
        .fwd_reg       (fwd_reg),
        .fwd_data      (fwd_data),
        .fwd_ready     (fwd_ready),
        .long_done     (long_done),
        .long_done_reg (long_done_reg),
        .flush         (flush),
        .stall         (stall),
        .ex_valid      (ex_valid),
        .ex_rs_data    (ex_rs_data),
        .ex_wb_en      (ex_wb_en),
        .ex_wb_reg     (ex_wb_reg),
        .stall_count   (stall_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_valid      = 1'b0;
        id_rs_reg     = '0;
        id_rs_used    = '0;
        id_rf_data    = '0;
        id_wb_en      = 1'b0;
        id_wb_reg     = '0;
        id_long       = 1'b0;
        fwd_en        = '0;
        fwd_reg       = '0;
        fwd_data      = '0;
        fwd_ready     = '0;
        long_done     = 1'b0;
        long_done_reg = '0;
        flush         = 1'b0;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Present a reader of register r on port 0 with the given regfile data.
    task automatic reader(input logic [4:0] r, input logic [31:0] rf);
        idle();
        id_valid      = 1'b1;
        id_rs_reg[0]  = r;
        id_rs_used[0] = 1'b1;
        id_rf_data[0] = rf;
    endtask

    // Present a long-latency writer of register r.
    task automatic long_op(input logic [4:0] r);
        idle();
        id_valid  = 1'b1;
        id_wb_en  = 1'b1;
        id_wb_reg = r;
        id_long   = 1'b1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #1;
        check("rst_ex_valid", ex_valid, 0);
        check("rst_ex_wb_en", ex_wb_en, 0);
        check("rst_ex_wb_reg", ex_wb_reg, 0);
        check("rst_ex_rs0", ex_rs_data[0], 0);
        check("rst_stall_count", stall_count, 0);
        check("rst_stall", stall, 0);
        cycle();
        cycle();
        reset = 1'b0;

        // RAW: EX and MEM both write x5, EX is youngest and wins.
        idle();
        id_valid = 1'b1;
        id_rs_reg[0] = 5'd5;  id_rs_used[0] = 1'b1; id_rf_data[0] = 32'hAAAA;
        id_rs_reg[1] = 5'd6;  id_rs_used[1] = 1'b1; id_rf_data[1] = 32'h66;
        id_wb_en = 1'b1; id_wb_reg = 5'd10;
        fwd_en = 3'b011; fwd_ready = 3'b111;
        fwd_reg[0] = 5'd5; fwd_data[0] = 32'h11;
        fwd_reg[1] = 5'd5; fwd_data[1] = 32'h22;
        #1;
        check("raw_stall", stall, 0);
        cycle();
        check("raw_ex_valid", ex_valid, 1);
        check("raw_rs0", ex_rs_data[0], 32'h11);
        check("raw_rs1_rf", ex_rs_data[1], 32'h66);
        check("raw_wb_en", ex_wb_en, 1);
        check("raw_wb_reg", ex_wb_reg, 10);

        // Only WB (index 2) matches on port 1, MEM on port 0.
        fwd_en = 3'b110;
        fwd_reg[2] = 5'd6; fwd_data[2] = 32'h33;
        #1;
        check("old_src_stall", stall, 0);
        cycle();
        check("mem_fwd_rs0", ex_rs_data[0], 32'h22);
        check("wb_fwd_rs1", ex_rs_data[1], 32'h33);

        // Load-use: load to x7 still in EX.
        idle();
        id_valid = 1'b1;
        id_rs_reg[1] = 5'd7; id_rs_used[1] = 1'b1; id_rf_data[1] = 32'h1;
        id_wb_en = 1'b1; id_wb_reg = 5'd11;
        fwd_en = 3'b001; fwd_reg[0] = 5'd7; fwd_ready = 3'b000;
        #1;
        check("lu_stall", stall, 1);
        cycle();
        exp_cnt++;
        check("lu_bubble_valid", ex_valid, 0);
        check("lu_bubble_wb_en", ex_wb_en, 0);
        check("lu_hold_rs1", ex_rs_data[1], 32'h33);
        check("lu_hold_wb_reg", ex_wb_reg, 10);
        check("lu_count", stall_count, exp_cnt);
        fwd_en = 3'b010; fwd_reg[1] = 5'd7; fwd_data[1] = 32'hDEAD; fwd_ready = 3'b010;
        #1;
        check("lu_release", stall, 0);
        cycle();
        check("lu_valid", ex_valid, 1);
        check("lu_data", ex_rs_data[1], 32'hDEAD);

        // Long op to x9.
        long_op(5'd9);
        #1;
        check("long_issue_stall", stall, 0);
        cycle();
        check("long_ex_valid", ex_valid, 1);
        check("long_ex_wb_en", ex_wb_en, 0);
        check("long_ex_wb_reg", ex_wb_reg, 9);
        reader(5'd9, 32'h0);
        #1;
        check("long_rd_stall1", stall, 1);
        cycle();
        exp_cnt++;
        // Writer to x9 while busy: WAW.
        idle();
        id_valid = 1'b1; id_wb_en = 1'b1; id_wb_reg = 5'd9;
        #1;
        check("long_waw_stall", stall, 1);
        cycle();
        exp_cnt++;
        check("long_waw_valid", ex_valid, 0);
        reader(5'd9, 32'h0);
        #1;
        check("long_rd_stall3", stall, 1);
        cycle();
        exp_cnt++;
        long_done = 1'b1; long_done_reg = 5'd9;
        #1;
        check("long_done_stall", stall, 1);
        cycle();
        exp_cnt++;
        reader(5'd9, 32'h99);
        #1;
        check("long_released", stall, 0);
        cycle();
        check("long_rd_valid", ex_valid, 1);
        check("long_rd_data", ex_rs_data[0], 32'h99);
        check("long_count", stall_count, exp_cnt);

        // x0: every source writes x0, must not forward nor stall.
        idle();
        id_valid = 1'b1;
        id_rs_used = 2'b11;
        id_rf_data[1] = 32'h1234;
        fwd_en = 3'b111; fwd_ready = 3'b000;
        fwd_data[0] = 32'hFFFF; fwd_data[1] = 32'hFFFF; fwd_data[2] = 32'hFFFF;
        #1;
        check("x0_stall", stall, 0);
        cycle();
        check("x0_rs0", ex_rs_data[0], 0);
        check("x0_rs1", ex_rs_data[1], 0);

        // Flush during a long-op hazard on x12.
        long_op(5'd12);
        cycle();
        reader(5'd12, 32'h0);
        flush = 1'b1;
        #1;
        check("flush_stall", stall, 0);
        cycle();
        check("flush_valid", ex_valid, 0);
        check("flush_wb_en", ex_wb_en, 0);
        flush = 1'b0;
        #1;
        check("flush_busy_kept", stall, 1);
        cycle();
        exp_cnt++;
        check("flush_count", stall_count, exp_cnt);

        // Same-cycle set and clear of x3: set wins.
        long_op(5'd3);
        long_done = 1'b1; long_done_reg = 5'd3;
        #1;
        check("setclr_issue", stall, 0);
        cycle();
        reader(5'd3, 32'h0);
        #1;
        check("setclr_busy", stall, 1);
        cycle();
        exp_cnt++;
        check("setclr_count", stall_count, exp_cnt);

        // Asynchronous reset mid-stall.
        #2;
        reset = 1'b1;
        #1;
        check("arst_count", stall_count, 0);
        check("arst_stall", stall, 0);
        check("arst_ex_valid", ex_valid, 0);
        cycle();
        reset = 1'b0;
        reader(5'd12, 32'h5);
        #1;
        check("arst_no_stale_busy", stall, 0);
        cycle();
        check("arst_post_valid", ex_valid, 1);
        check("arst_post_data", ex_rs_data[0], 32'h5);
        check("arst_post_count", stall_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv32i_hazardunit.md
# rv32i_hazardUnit

Parametrised operand-forwarding, hazard-detection and ID/EX staging block for the rv32i pipeline. It sits between the decode stage and the execute stage and replaces fixed three-source (EX/MEM/WB) forwarding with a configurable number of read ports and forwarding sources. It adds three things fixed forwarding lacks: load-use stall detection, a busy-bit scoreboard for long-latency (multi-cycle) writers, and a registered ID/EX boundary with stall-bubble and flush handling. A free-running stall-cycle counter is provided for debug.

## Interface
- NUM_RD, 2: number of source-operand read ports (1..3)
- NUM_FWD, 3: number of forwarding sources; index 0 is the youngest (EX), higher indices are older
- XLEN, 32: data width
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  decode stage holds a valid instruction
- id_rs_reg  in  NUM_RD×5  source register numbers
- id_rs_used  in  NUM_RD  port actually read by the instruction
- id_rf_data  in  NUM_RD×XLEN  register-file read data
- id_wb_en  in  1  instruction writes a register
- id_wb_reg  in  5  destination register
- id_long  in  1  instruction is a long-latency writer, completed via long_done
- fwd_en  in  NUM_FWD  source holds a pending register write
- fwd_reg  in  NUM_FWD×5  source destination register
- fwd_data  in  NUM_FWD×XLEN  source result
- fwd_ready  in  NUM_FWD  fwd_data is valid (0 for a load still in EX)
- long_done  in  1  long-latency result written back this cycle
- long_done_reg  in  5  register completed by long_done
- flush  in  1  kill the instruction in decode (taken jump)
- stall  out  1  hold IF/ID; combinational
- ex_valid  out  1  registered: EX stage holds a valid instruction
- ex_rs_data  out  NUM_RD×XLEN  registered resolved operands
- ex_wb_en  out  1  registered writeback enable
- ex_wb_reg  out  5  registered destination register
- stall_count  out  32  saturating count of stall cycles

## Operation
- Operand resolution, per port p:
  - Select the lowest-index source i with fwd_en[i] & fwd_reg[i]==id_rs_reg[p] & id_rs_reg[p]!=0.
  - If a match exists, the operand is fwd_data[i]; otherwise it is id_rf_data[p].
  - Register x0 always resolves to 0 and is never forwarded.
- Hazard, per port p: raised if id_rs_used[p] and either
  - the selected match has fwd_ready[i]=0, or
  - busy[id_rs_reg[p]]=1.
- WAW hazard: raised if id_wb_en & busy[id_wb_reg] & id_wb_reg!=0.
- stall = id_valid & !flush & (any hazard).
- Issue = id_valid & !stall & !flush.
- Scoreboard: busy[31:1] register, busy[0] hard-wired 0.
  - issue & id_long & id_wb_en & id_wb_reg!=0 sets busy[id_wb_reg].
  - long_done clears busy[long_done_reg].
  - Same register set and cleared in one cycle: the set wins (busy stays 1).
  - flush does not clear busy bits; already-issued long ops remain in flight.
- ID/EX register, per cycle:
  - On issue: ex_valid←1; ex_rs_data←resolved operands; ex_wb_en←id_wb_en & !id_long; ex_wb_reg←id_wb_reg. A long op writes back through long_done, not through EX.
  - Otherwise (stall, flush or !id_valid): a bubble is inserted, ex_valid←0 and ex_wb_en←0. ex_rs_data and ex_wb_reg hold their previous values.
- stall_count increments on each cycle with stall=1 and saturates at 0xFFFF_FFFF.

## Timing
- Reset (asynchronous):
  - ex_valid=0, ex_wb_en=0, ex_wb_reg=0, ex_rs_data=0.
  - busy=0, stall_count=0.
  - stall follows its inputs combinationally and reads 0 while busy=0 with no unready matches.
- Latency:
  - Decode to EX outputs: 1 cycle.
  - stall is valid in the same cycle as its inputs.
  - A busy bit set by issue in cycle n is visible to the hazard check in cycle n+1.
  - A long_done in cycle n releases a dependent instruction in cycle n+1. The register-file write lands in the same cycle; the regfile is write-through, so id_rf_data is current in n+1.
- Load-use: a load in EX (fwd_ready[0]=0) followed by a dependent instruction gives exactly one stall cycle. The next cycle the load sits in MEM at index 1 with ready=1 and its data is forwarded.
- flush with stall in the same cycle: flush wins, stall=0, and a bubble is issued.
- Reset asserted mid-stall or mid-long-op: all state clears on the reset edge, and no stale busy bits survive.

## Structure
- Shared package rv32i_pkg holds REG_ADDR_W=5, XLEN, the reg_addr_t and word_t typedefs, and the REG_ZERO constant.
- Sub-module rv32i_fwdMux: one instance per read port, generated NUM_RD times. Each instance does the priority match, operand select and per-port hazard bit, and is purely combinational. The scoreboard, ID/EX register and counter live in the top.

## Test plan
- RAW with forwarding: EX writes x5=0x11, MEM writes x5=0x22, ID reads x5 → stall=0, ex_rs_data[0]=0x11 the next cycle.
- Load-use: load to x7 in EX with ready=0 and ID reads x7 → stall=1 for one cycle and ex_valid=0. The following cycle the load is in MEM with data 0xDEAD, ex_rs_data=0xDEAD and ex_valid=1.
- Long op:
  - Issue a long op to x9 → busy[9]=1.
  - A reader of x9 stalls for 4 cycles until long_done(x9); stall_count=4.
  - A writer to x9 issued meanwhile also stalls (WAW).
- x0: all sources write x0 with data 0xFFFF, ID reads x0 with rf_data=0 → operand 0, no stall.
- Flush during stall: flush=1 while a hazard is present → stall=0 and ex_valid=0 next cycle; busy bits unchanged.
- Same-cycle set/clear and reset: long_done(x3) with issue of a long op to x3 → busy[3]=1. Asserting reset mid-sequence clears busy and stall_count asynchronously, before the next clk edge.
